// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier that drives an external adder/subtractor.
// Define MULT_EARLY_TERM_EN to stop once the remaining multiplier bits are all sign.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_ovf,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             msb;
    logic             fin;
`ifdef MULT_EARLY_TERM_EN
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   shamt;
    logic [WIDTH:0]     mask;
    logic [WIDTH:0]     rest;
    logic [2*WIDTH-1:0] wide;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        exc_d   = exc_q;
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        msb     = 1'b0;
        fin     = 1'b0;
`ifdef MULT_EARLY_TERM_EN
        k       = '0;
        shamt   = '0;
        mask    = '0;
        rest    = '0;
        wide    = '0;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (ctrl_MULT) begin
                    state_d = RUN;
                    m_d     = data_operandA;
                    q_d     = data_operandB;
                    p_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    exc_d   = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                add_a = p_q;
                unique case ({q_q[0], qm1_q})
                    2'b10: begin
                        add_b   = m_q;
                        add_sub = 1'b1;
                    end
                    2'b01:   add_b = m_q;
                    default: add_b = '0;
                endcase
                // Sign of the true 33-bit sum, so M = most-negative still works
                msb                = add_sum[WIDTH-1] ^ add_ovf;
                {p_d, q_d, qm1_d}  = {msb, add_sum, q_q};
                cnt_d              = cnt_q + 1'b1;
                fin                = (cnt_q == LAST);
`ifdef MULT_EARLY_TERM_EN
                // Low bits of {Q,q_m1} still hold unprocessed multiplier bits
                k     = cnt_q + 1'b1;
                shamt = CNT_W'(WIDTH) - k;
                mask  = {(WIDTH + 1){1'b1}} >> k;
                rest  = {q_d, qm1_d} & mask;
                if (rest == '0 || rest == mask) begin
                    fin = 1'b1;
                end
                if (fin) begin
                    wide       = $signed({p_d, q_d}) >>> shamt;
                    {p_d, q_d} = wide;
                end
`endif
                if (fin) begin
                    state_d = DONE;
                    res_d   = q_d;
                    exc_d   = (p_d != {WIDTH{q_d[WIDTH-1]}});
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq with a behavioural 32-bit adder attached.
// Expected latencies follow MULT_EARLY_TERM_EN when it is defined.
module tb_booth_mult_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] add_sum;
    logic        add_ovf;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

`ifdef MULT_EARLY_TERM_EN
    localparam int L_7N3 = 4;
    localparam int L_MIN = 2;
    localparam int L_BIG = 19;
    localparam int L_NN  = 2;
    localparam int L_53  = 4;
    localparam int L_M2  = 4;
    localparam int L_MM  = 33;
    localparam int REP   = 2;
`else
    localparam int L_7N3 = 33;
    localparam int L_MIN = 33;
    localparam int L_BIG = 33;
    localparam int L_NN  = 33;
    localparam int L_53  = 33;
    localparam int L_M2  = 33;
    localparam int L_MM  = 33;
    localparam int REP   = 5;
`endif

    booth_mult_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .add_a          (add_a),
        .add_b          (add_b),
        .add_sub        (add_sub),
        .add_sum        (add_sum),
        .add_ovf        (add_ovf),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    always_comb begin
        add_sum = add_sub ? (add_a - add_b) : (add_a + add_b);
        if (add_sub)
            add_ovf = (add_a[31] != add_b[31]) && (add_sum[31] != add_a[31]);
        else
            add_ovf = (add_a[31] == add_b[31]) && (add_sum[31] != add_a[31]);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res,
                           input logic exc, input int lat, input int rep,
                           input bit b2b, input bit chk_add);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        while (!seen && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (chk_add && n == 1) begin
                check({tag, "_add_a"}, add_a, 0);
                check({tag, "_add_b"}, add_b, a);
                check({tag, "_add_sub"}, add_sub, 1);
                check({tag, "_busy_run"}, busy, 1);
            end
            if (data_resultRDY) begin
                seen = 1'b1;
            end else begin
                @(negedge clock);
                ctrl_MULT     = (n + 1 == rep);
                data_operandA = 32'h0000_0064;
                data_operandB = 32'h0000_0064;
            end
        end
        check({tag, "_rdy_seen"}, seen, 1);
        check({tag, "_latency"}, n, lat);
        check({tag, "_result"}, data_result, res);
        check({tag, "_exc"}, data_exception, exc);
        check({tag, "_busy_done"}, busy, 0);
        if (!b2b) begin
            @(negedge clock);
            ctrl_MULT = 1'b0;
            @(posedge clock);
            #1;
            check({tag, "_rdy_pulse"}, data_resultRDY, 0);
            check({tag, "_hold_res"}, data_result, res);
            check({tag, "_hold_exc"}, data_exception, exc);
            check({tag, "_idle_busy"}, busy, 0);
        end
    endtask

    initial begin
        int pulses;
        #12;
        check("rst_result", data_result, 0);
        check("rst_exc", data_exception, 0);
        check("rst_rdy", data_resultRDY, 0);
        check("rst_busy", busy, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_sub", add_sub, 0);
        @(negedge clock);
        reset_n       = 1'b1;
        data_operandA = 32'h1234_5678;
        data_operandB = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        check("idle_add_b", add_b, 0);
        check("idle_busy", busy, 0);

        do_mult("m7xn3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0,
                L_7N3, 0, 1'b0, 1'b1);
        do_mult("min_x_n1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                1'b1, L_MIN, 0, 1'b0, 1'b0);
        do_mult("big", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000,
                1'b1, L_BIG, 0, 1'b0, 1'b0);
        do_mult("min_x_2", 32'h8000_0000, 32'h0000_0002, 32'h0000_0000,
                1'b1, L_M2, 0, 1'b0, 1'b0);
        do_mult("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'h0000_0000,
                1'b1, L_MM, 0, 1'b0, 1'b0);
        do_mult("m5x3", 32'd5, 32'd3, 32'd15, 1'b0, L_53, 0, 1'b1, 1'b0);
        do_mult("n1xn1_b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001,
                1'b0, L_NN, 0, 1'b0, 1'b0);
        do_mult("repulse", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0,
                L_7N3, REP, 1'b0, 1'b0);

        @(negedge clock);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'h8000_0000;
        data_operandB = 32'h8000_0000;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rdy", data_resultRDY, 0);
        check("arst_result", data_result, 0);
        check("arst_exc", data_exception, 0);
        check("arst_add_a", add_a, 0);
        check("arst_add_b", add_b, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        check("arst_no_rdy", pulses, 0);
        do_mult("after_rst", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0,
                L_7N3, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
